// File: rtl/svm_window_scorer.sv
// ============================================================================
// Module   : svm_window_scorer
// Purpose  : Linear-SVM dot product over one HOG window (blocks x features),
//            with ROM weight fetch, bias add and human/no-human decision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module svm_window_scorer #(
    parameter int NUM_BLOCKS     = 105,
    parameter int FEAT_PER_BLOCK = 36,
    parameter int FEAT_W         = 16,
    parameter int WGT_W          = 16,
    parameter int ACC_W          = 44,
    parameter int ADDR_W         = 12,
    parameter logic signed [ACC_W-1:0] BIAS   = '0,
    parameter logic signed [ACC_W-1:0] THRESH = '0
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [6:0]               iBlockIdx,
    input  logic                     iFeatValid,
    input  logic signed [FEAT_W-1:0] iFeature,
    output logic [ADDR_W-1:0]        oWAddr,
    input  logic signed [WGT_W-1:0]  iWeight,
    output logic                     oScoreValid,
    output logic signed [ACC_W-1:0]  oScore,
    output logic                     oHuman,
    output logic                     oIncomplete,
    output logic                     oOverrun
);

    localparam int PROD_W = FEAT_W + WGT_W;
    localparam int TOTAL  = NUM_BLOCKS * FEAT_PER_BLOCK;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int FIDX_W = $clog2(FEAT_PER_BLOCK + 1);

    localparam logic [6:0]        C_NUM_BLK   = 7'(NUM_BLOCKS);
    localparam logic [6:0]        C_LAST_BLK  = 7'(NUM_BLOCKS - 1);
    localparam logic [FIDX_W-1:0] C_FULL      = FIDX_W'(FEAT_PER_BLOCK);
    localparam logic [FIDX_W-1:0] C_LAST_FEAT = FIDX_W'(FEAT_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]  C_TOTAL     = CNT_W'(TOTAL);
    localparam logic [31:0]       C_FPB_BITS  = 32'(FEAT_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Front end: block tracking and feature index
    logic [6:0]        prevBlk_q, prevBlk_d;
    logic [FIDX_W-1:0] featIdx_q, featIdx_d;
    logic [FIDX_W-1:0] effIdx;
    logic              blkInRange, accept, overrun_d, overrun_q;
    logic              isFirst, isLast;
    logic [ADDR_W-1:0] blkExt, addrSum;

    // Pipeline stages
    logic                     s1Valid_q, s1First_q, s1Last_q;
    logic signed [FEAT_W-1:0] s1Feat_q;
    logic                     s2Valid_q, s2First_q, s2Last_q;
    logic signed [PROD_W-1:0] s2Prod_q;

    // Accumulator and result
    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic                    human_q, human_d;
    logic                    incomplete_q, incomplete_d;
    logic signed [ACC_W-1:0] prodExt, sumAdd, scoreWithBias;

    always_comb begin
        blkInRange = (iBlockIdx < C_NUM_BLK);
        effIdx     = (iBlockIdx != prevBlk_q) ? '0 : featIdx_q;
        accept     = iFeatValid && blkInRange && (effIdx < C_FULL);
        overrun_d  = iFeatValid && blkInRange && (effIdx >= C_FULL);
        isFirst    = (iBlockIdx == 7'd0) && (effIdx == '0);
        isLast     = (iBlockIdx == C_LAST_BLK) && (effIdx == C_LAST_FEAT);
        prevBlk_d  = prevBlk_q;
        featIdx_d  = featIdx_q;
        if (iFeatValid) begin
            prevBlk_d = iBlockIdx;
            featIdx_d = accept ? (effIdx + 1'b1) : effIdx;
        end
    end

    // Block index times FEAT_PER_BLOCK as a sum of shifted copies
    always_comb begin
        blkExt  = ADDR_W'(iBlockIdx);
        addrSum = ADDR_W'(effIdx);
        for (int b = 0; b < 32; b++) begin
            if (C_FPB_BITS[b]) begin
                addrSum = addrSum + (blkExt << b);
            end
        end
    end

    assign oWAddr = addrSum;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prevBlk_q <= '0;
            featIdx_q <= '0;
            overrun_q <= 1'b0;
            s1Valid_q <= 1'b0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Feat_q  <= '0;
            s2Valid_q <= 1'b0;
            s2First_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Prod_q  <= '0;
        end else begin
            prevBlk_q <= prevBlk_d;
            featIdx_q <= featIdx_d;
            overrun_q <= overrun_d;
            s1Valid_q <= accept;
            s1First_q <= accept && isFirst;
            s1Last_q  <= accept && isLast;
            s1Feat_q  <= iFeature;
            s2Valid_q <= s1Valid_q;
            s2First_q <= s1First_q;
            s2Last_q  <= s1Last_q;
            s2Prod_q  <= s1Feat_q * iWeight;
        end
    end

    // The accumulator stage owns the window state so a new "first" can overlap DONE
    always_comb begin
        prodExt       = {{(ACC_W - PROD_W){s2Prod_q[PROD_W-1]}}, s2Prod_q};
        sumAdd        = acc_q + prodExt;
        scoreWithBias = sumAdd + BIAS;
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        human_d       = human_q;
        incomplete_d  = incomplete_q;

        case (state_q)
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (s2Valid_q) begin
            if (s2First_q) begin
                acc_d   = prodExt;
                cnt_d   = CNT_W'(1);
                state_d = ST_ACCUM;
            end else if (state_q == ST_ACCUM) begin
                acc_d = sumAdd;
                cnt_d = cnt_q + 1'b1;
                if (s2Last_q) begin
                    state_d      = ST_DONE;
                    score_d      = scoreWithBias;
                    human_d      = (scoreWithBias > THRESH);
                    incomplete_d = ((cnt_q + 1'b1) != C_TOTAL);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            score_q      <= '0;
            human_q      <= 1'b0;
            incomplete_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            human_q      <= human_d;
            incomplete_q <= incomplete_d;
        end
    end

    assign oScoreValid = (state_q == ST_DONE);
    assign oScore      = score_q;
    assign oHuman      = human_q;
    assign oIncomplete = incomplete_q;
    assign oOverrun    = overrun_q;

endmodule

`default_nettype wire
